// File: rtl/psum_sched.sv
// Round-robin scheduler: grants one PE row at a time, sums GROUP_LEN psums from it,
// and presents the group sum with the row ID. Define PSUM_SCHED_SAT_EN for saturating adds.
module psum_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int GROUP_LEN = 3,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      busy
);

  localparam int CNT_W = $clog2(GROUP_LEN);

  typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   pick_id;
  logic              pick_vld;
  logic [DATA_W-1:0] beat_data;
  logic [DATA_W-1:0] sum;
  logic              beat;
  logic              last_beat;
  logic              out_fire;

  function automatic logic [DATA_W-1:0] add_psum(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
`ifdef PSUM_SCHED_SAT_EN
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? '1 : s[DATA_W-1:0];
`else
    return a + b;
`endif
  endfunction

  // Search downward so the smallest offset past last_grant is the final winner.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_valid[(int'(last_grant) + i) % NUM_REQ]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

  assign beat_data = req_data[int'(grant_id)*DATA_W +: DATA_W];
  assign beat      = (state == COLLECT) && en && req_valid[grant_id];
  assign last_beat = beat && (cnt == CNT_W'(GROUP_LEN - 1));
  assign sum       = add_psum(acc, beat_data);
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state != IDLE);

  // Ready comes from registered grant and en only, never from req_valid.
  always_comb begin
    req_ready = '0;
    if (state == COLLECT && en) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && pick_vld) state_nxt = COLLECT;
      COLLECT: if (last_beat)      state_nxt = OUTPUT;
      OUTPUT:  if (out_fire)       state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      cnt        <= '0;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && pick_vld) begin
            grant_id <= pick_id;
            acc      <= '0;
            cnt      <= '0;
          end
        end
        COLLECT: begin
          if (beat) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              out_data  <= sum;
              out_id    <= grant_id;
              out_valid <= 1'b1;
            end
          end
        end
        OUTPUT: begin
          // en is deliberately ignored here so a finished result always drains.
          if (out_fire) begin
            out_valid  <= 1'b0;
            last_grant <= grant_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_sched.sv
// Self-checking bench for psum_sched: per-requester data queues drive the DUT, an
// expected-result queue is filled at stimulus time and drained by an output monitor.
module tb_psum_sched;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int GROUP_LEN = 3;
  localparam int ID_W      = $clog2(NUM_REQ);
  localparam int MAXV      = (1 << DATA_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      en = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic                      out_ready = 1'b1;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;
  logic                      busy;

  psum_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .GROUP_LEN(GROUP_LEN), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int                n_checks = 0;
  int                n_pass = 0;
  int                cyc = 0;
  int                n_out = 0;
  int                rise_cyc = 0;
  int                beat_cnt [NUM_REQ];
  int                last_beat_cyc [NUM_REQ];
  logic [DATA_W-1:0] dq [NUM_REQ][$];
  exp_t              exp_q [$];
  int                last_id = NUM_REQ - 1;
  logic [NUM_REQ-1:0] rr_seen = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [DATA_W-1:0] add_ref(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    int s;
    s = int'(a) + int'(b);
`ifdef PSUM_SCHED_SAT_EN
    if (s > MAXV) s = MAXV;
`else
    s = s % (MAXV + 1);
`endif
    return s[DATA_W-1:0];
  endfunction

  // Queue one group for requester r and record the result the DUT owes for it.
  task automatic push_group(input int r, input logic [DATA_W-1:0] v [GROUP_LEN]);
    logic [DATA_W-1:0] s;
    exp_t e;
    s = '0;
    for (int j = 0; j < GROUP_LEN; j++) begin
      dq[r].push_back(v[j]);
      s = add_ref(s, v[j]);
    end
    e.data = s;
    e.id   = r[ID_W-1:0];
    exp_q.push_back(e);
    last_id = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic bit pending();
    bit p;
    p = (exp_q.size() != 0);
    for (int i = 0; i < NUM_REQ; i++) if (dq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input string name, input int max_cyc, input bit rnd);
    int n;
    n = 0;
    while (pending() && n < max_cyc) begin
      tick();
      if (rnd) begin
        en        = ($urandom_range(0, 3) != 0);
        out_ready = $urandom_range(0, 1) != 0;
      end
      n++;
    end
    en        = 1'b1;
    out_ready = 1'b1;
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // Requester driver: a requester is valid while its queue holds data, head on the bus.
  initial begin
    logic [NUM_REQ-1:0] bm;
    for (int i = 0; i < NUM_REQ; i++) begin
      beat_cnt[i] = 0;
      last_beat_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      bm = rst ? (req_valid & req_ready) : '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bm[i]) begin
          beat_cnt[i]++;
          last_beat_cyc[i] = cyc;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bm[i] && dq[i].size() != 0) void'(dq[i].pop_front());
        req_valid[i] = (dq[i].size() != 0);
        req_data[i*DATA_W +: DATA_W] = (dq[i].size() != 0) ? dq[i][0] : '0;
      end
    end
  end

  // Output monitor and protocol checks, sampled on the falling edge.
  initial begin
    logic              prev_hold;
    logic              after_fire;
    logic              prev_ov;
    logic [DATA_W-1:0] p_data;
    logic [ID_W-1:0]   p_id;
    exp_t              e;
    prev_hold = 1'b0; after_fire = 1'b0; prev_ov = 1'b0; p_data = '0; p_id = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_hold = 1'b0; after_fire = 1'b0; prev_ov = 1'b0;
      end else begin
        rr_seen |= req_ready;
        check("req_ready_onehot0", $onehot0(req_ready), 1);
        if (!en)       check("req_ready_en_low", req_ready, 0);
        if (out_valid) check("req_ready_in_output", req_ready, 0);
        if (after_fire) begin
          check("busy_after_accept", busy, 0);
          check("out_valid_after_accept", out_valid, 0);
        end
        if (prev_hold) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", out_data, p_data);
          check("hold_id", out_id, p_id);
        end
        if (out_valid && !prev_ov) rise_cyc = cyc;
        after_fire = out_valid && out_ready;
        if (after_fire) begin
          n_out++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result: got data %0d id %0d, none expected", out_data, out_id);
          end else begin
            e = exp_q.pop_front();
            check("result_data", out_data, e.data);
            check("result_id", out_id, e.id);
          end
        end
        prev_hold = out_valid && !out_ready;
        p_data    = out_data;
        p_id      = out_id;
        prev_ov   = out_valid;
      end
    end
  end

  initial begin
    int b0;
    int n;
    int n_save;
    logic [NUM_REQ-1:0] mask;
    logic [DATA_W-1:0] vals [GROUP_LEN];

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Requesters 0 and 2 always valid, data 1: results alternate 0,2,0,2
    rr_seen = '0;
    push_group(0, '{1, 1, 1});
    push_group(2, '{1, 1, 1});
    push_group(0, '{1, 1, 1});
    push_group(2, '{1, 1, 1});
    wait_drain("alt_0_2", 200, 1'b0);
    check("alt_no_ready_1_3", rr_seen & 4'b1010, 0);

    // Requester 0 alone: 12+5+2, latency and beat count
    b0 = beat_cnt[0];
    push_group(0, '{12, 5, 2});
    wait_drain("single_r0", 100, 1'b0);
    check("single_r0_beats", beat_cnt[0] - b0, 3);
    check("single_r0_latency", rise_cyc - last_beat_cyc[0], 1);

    // Requester 1: 200+100+10 wraps (or saturates)
    push_group(1, '{200, 100, 10});
    wait_drain("wrap_r1", 100, 1'b0);

    // Output back-pressure for 5 cycles
    out_ready = 1'b0;
    push_group(2, '{30, 40, 50});
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("bp_valid_seen", out_valid, 1);
    n_save = n_out;
    repeat (5) tick();
    check("bp_no_accept", n_out, n_save);
    check("bp_ready_low", req_ready, 0);
    out_ready = 1'b1;
    tick();
    check("bp_accept_on_rise", n_out, n_save + 1);
    wait_drain("backpressure", 50, 1'b0);

    // Enable stall mid-group on requester 3
    b0 = beat_cnt[3];
    push_group(3, '{7, 8, 9});
    n = 0;
    while (beat_cnt[3] == b0 && n < 100) begin
      tick();
      n++;
    end
    en = 1'b0;
    repeat (4) tick();
    check("stall_beats", beat_cnt[3] - b0, 1);
    check("stall_ready", req_ready, 0);
    check("stall_busy", busy, 1);
    en = 1'b1;
    wait_drain("stall_r3", 100, 1'b0);

    // Random batches: a random set of requesters, all continuously valid, rotate fairly
    for (int b = 0; b < 10; b++) begin
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      n = $urandom_range(1, 3) * $countones(mask);
      for (int g = 0; g < n; g++) begin
        do last_id = (last_id + 1) % NUM_REQ; while (!mask[last_id]);
        for (int j = 0; j < GROUP_LEN; j++) vals[j] = DATA_W'($urandom_range(0, MAXV));
        push_group(last_id, vals);
      end
      wait_drain("random_batch", 3000, 1'b1);
    end

    // Asynchronous reset mid-group, then requesters 0 and 1
    b0 = beat_cnt[2];
    push_group(2, '{50, 60, 70});
    n = 0;
    while (beat_cnt[2] == b0 && n < 100) begin
      tick();
      n++;
    end
    check("arst_busy_before", busy, 1);
    #1 rst = 1'b0;
    #1;
    check("arst_req_ready", req_ready, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    for (int i = 0; i < NUM_REQ; i++) dq[i].delete();
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    last_id = NUM_REQ - 1;
    push_group(0, '{3, 4, 5});
    push_group(1, '{6, 7, 8});
    wait_drain("after_reset", 100, 1'b0);

    repeat (3) tick();
    check("final_idle", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/psum_sched.md
Name: psum_sched

Overview:
- Round-robin scheduler that shares one partial-sum accumulation datapath between NUM_REQ PE rows.
- Grants one requester at a time and takes exactly GROUP_LEN psums from it under valid/ready, summing them into one result.
- Presents the result with the requester ID on a valid/ready output port, then re-arbitrates.
- Sits between the PE-row psum outputs and the output buffer/activation stage.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 8, psum and result width (unsigned)
GROUP_LEN, 3, psums summed per grant (>=2)
ID_W, $clog2(NUM_REQ), width of out_id

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
en  in  1  global enable; low = stall intake, no new grants
req_valid  in  NUM_REQ  per-requester psum valid
req_data  in  NUM_REQ*DATA_W  packed psums, requester i at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  per-requester accept, at most one bit high
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  DATA_W  group sum
out_id  out  ID_W  requester that produced out_data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=0): state=IDLE, acc=0, cnt=0, grant_id=0, last_grant=NUM_REQ-1; out_valid=0, out_data=0, out_id=0, req_ready=0, busy=0.
  - Takes effect immediately without a clock edge, including mid-group.
  - A partial group is discarded.
- FSM states: IDLE, COLLECT, OUTPUT.
- IDLE:
  - If en=1 and any req_valid=1, pick the first valid index searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register it as grant_id, clear acc and cnt, go to COLLECT.
  - Arbitration costs one cycle. req_ready=0 in IDLE.
- COLLECT:
  - req_ready[grant_id]=en; all other bits 0. req_ready is decoded from registered state only; there is no combinational path from req_valid.
  - A beat occurs when req_valid[grant_id] and req_ready[grant_id] are both high. On each beat: acc <= acc + data, cnt <= cnt+1.
  - On the beat with cnt==GROUP_LEN-1: out_data <= acc + data, out_id <= grant_id, out_valid <= 1, go to OUTPUT.
  - req_valid low: wait, state held. Other requesters' valids are ignored until the group completes.
- OUTPUT:
  - out_valid, out_data and out_id stay stable until out_ready=1.
  - On out_valid and out_ready both high: out_valid <= 0, last_grant <= grant_id, go to IDLE.
  - en has no effect in OUTPUT; a pending result always drains.
- en=0:
  - IDLE: no grant taken.
  - COLLECT: req_ready forced 0; acc, cnt and grant_id held; resumes exactly where it stopped.
- Arithmetic:
  - Unsigned, DATA_W bits, modulo 2^DATA_W wrap on every add (default build).
  - out_data is registered.
- Minimum group latency: grant cycle + GROUP_LEN beats + 1 output cycle.
  - Back-to-back groups with out_ready=1: GROUP_LEN+2 cycles per result.
- Fairness: the last-served requester has lowest priority next round. A requester holding valid continuously cannot starve others.
- Single requester valid: re-granted every round. Priority order is irrelevant.

Optional Feature:
PSUM_SCHED_SAT_EN
- Defined: each add saturates at 2^DATA_W-1. Once saturated, acc stays at max for the rest of the group.
- Undefined: modulo wrap as above.
- Interface and timing are identical in both builds.

Test Plan:
1. Requester 0 only, beats 12,5,2 with out_ready=1 -> req_ready[0] high for 3 beats; out_valid one cycle after third beat with out_data=19, out_id=0; busy low the cycle after acceptance.
2. Requester 1 beats 200,100,10 -> out_data=54 without PSUM_SCHED_SAT_EN; out_data=255 with it.
3. Requesters 0 and 2 valid continuously, data=1 each beat -> results out_id sequence 0,2,0,2, each out_data=3; req_ready never high for 1 or 3; never two req_ready bits high at once.
4. Group completes, out_ready held 0 for 5 cycles -> out_valid/out_data/out_id stable; all req_ready 0; result consumed on the cycle out_ready rises.
5. Requester 3, one beat (7), then en=0 for 4 cycles with req_valid high -> req_ready=0, no beats accepted; en=1, beats 8,9 -> out_data=24, out_id=3.
6. Async rst=0 asserted mid-COLLECT between clock edges -> req_ready, out_valid and busy go to 0 immediately. After release, requesters 0 and 1 valid -> first grant is 0.
